// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: state encoding and buffered fetch entry.
// The entry struct is sized to the default ADDR_WIDTH/DATA_WIDTH of instr_fetch_unit.
package fetch_pkg;

  localparam int unsigned ILEN_BYTES   = 4;
  localparam int unsigned ENTRY_PC_W   = 64;
  localparam int unsigned ENTRY_INST_W = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
    logic                    fault;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t, power-of-two depth, flush wins over push.
// Storage is reset so the head reads as all-zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               data_i,
  output fetch_entry_t               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT control, ROM sampling into a fetch FIFO for decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  rom_illegal_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]           fetched_cnt_o,
  output logic [63:0]           stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pop, push;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  fetch_entry_t          push_entry, head;

  always_comb begin
    pop  = ~fifo_empty & inst_ready_i;
    push = (state_q == RUN) & ((fifo_count < CNT_W'(FIFO_DEPTH)) | pop) & ~redirect_valid_i;

    push_entry.pc    = ENTRY_PC_W'(pc_q);
    push_entry.inst  = rom_illegal_i ? '0 : ENTRY_INST_W'(rom_data_i);
    push_entry.fault = rom_illegal_i;

    pc_d    = pc_q;
    state_d = state_q;
    // Redirect overrides everything; a faulting push parks the PC on the bad address.
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      state_d = RUN;
    end else if (push) begin
      if (rom_illegal_i) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(ILEN_BYTES);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid_i),
    .data_i (push_entry),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign rom_addr_o   = pc_q;
  assign inst_valid_o = ~fifo_empty;
  assign inst_o       = head.inst[DATA_WIDTH-1:0];
  assign inst_pc_o    = head.pc[ADDR_WIDTH-1:0];
  assign inst_fault_o = head.fault;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetched_cnt_q, fetched_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetched_cnt_d = fetched_cnt_q + {63'b0, push};
    stall_cnt_d   = stall_cnt_q + {63'b0, (state_q == RUN) & fifo_full & ~pop};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetched_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      fetched_cnt_q <= fetched_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign fetched_cnt_o = fetched_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
`else
  // The full flag only feeds the stall counter.
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios then random traffic against a queue model.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ill;
  logic        ready, redirect;
  logic [63:0] target;
  logic        valid, fault;
  logic [31:0] inst;
  logic [63:0] ipc;

  logic [63:0] w_addr, w_pc;
  logic [31:0] w_data, w_inst;
  logic        w_ill, w_valid, w_fault;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fcnt, scnt, w_fcnt, w_scnt;
`endif

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'h0) return 32'h0000_0013;
    if (a == 64'h4) return 32'h0010_0093;
    h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    return h ^ 32'h0000_0003;
  endfunction

  always_comb begin
    rom_data = rom_word(rom_addr);
    rom_ill  = (rom_addr[1:0] != 2'b00);
    w_data   = rom_word(w_addr);
    w_ill    = (w_addr[1:0] != 2'b00);
  end

  instr_fetch_unit #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(32),
    .RESET_PC  (64'h0),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .rom_illegal_i   (rom_ill),
    .redirect_valid_i(redirect),
    .redirect_pc_i   (target),
    .inst_valid_o    (valid),
    .inst_ready_i    (ready),
    .inst_o          (inst),
    .inst_pc_o       (ipc),
    .inst_fault_o    (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt_o   (fcnt),
    .stall_cnt_o     (scnt)
`endif
  );

  instr_fetch_unit #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(32),
    .RESET_PC  (64'hFFFF_FFFF_FFFF_FFFC),
    .FIFO_DEPTH(DEPTH)
  ) dut_wrap (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .rom_addr_o      (w_addr),
    .rom_data_i      (w_data),
    .rom_illegal_i   (w_ill),
    .redirect_valid_i(1'b0),
    .redirect_pc_i   (64'h0),
    .inst_valid_o    (w_valid),
    .inst_ready_i    (1'b1),
    .inst_o          (w_inst),
    .inst_pc_o       (w_pc),
    .inst_fault_o    (w_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt_o   (w_fcnt),
    .stall_cnt_o     (w_scnt)
`endif
  );

  // Reference model: an ordered list of fetched entries plus the next address to fetch.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          halted;
  logic [63:0] m_fetched, m_stall;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = 64'h0;
    halted    = 1'b0;
    m_fetched = 64'h0;
    m_stall   = 64'h0;
  endtask

  task automatic model_edge();
    ent_t e;
    bit   taken;
    taken = (mq.size() > 0) && ready;
    if (!halted && mq.size() == DEPTH && !taken) m_stall++;
    if (taken) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
      m_pc   = target;
      halted = 1'b0;
    end else if (!halted && mq.size() < DEPTH) begin
      e.pc    = m_pc;
      e.fault = (m_pc[1:0] != 2'b00);
      e.inst  = e.fault ? 32'h0 : rom_word(m_pc);
      mq.push_back(e);
      m_fetched++;
      if (e.fault) halted = 1'b1;
      else         m_pc   = m_pc + 64'd4;
    end
  endtask

  task automatic check_all();
    chk("rom_addr", rom_addr, m_pc);
    chk("valid", 64'(valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_pc", ipc, mq[0].pc);
      chk("head_inst", 64'(inst), 64'(mq[0].inst));
      chk("head_fault", 64'(fault), 64'(mq[0].fault));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetched_cnt", fcnt, m_fetched);
    chk("stall_cnt", scnt, m_stall);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    ready    = 1'b1;
    redirect = 1'b0;
    target   = 64'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_pc", ipc, 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_addr", rom_addr, 64'h0);
    chk("rst_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    rst_n = 1'b1;

    // Streaming from reset, plus the wrapping instance.
    step();
    chk("s1_pc", ipc, 64'h0);
    chk("s1_inst", 64'(inst), 64'h0000_0013);
    chk("wrap1_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap1_inst", 64'(w_inst), 64'(rom_word(64'hFFFF_FFFF_FFFF_FFFC)));
    chk("wrap1_fault", 64'(w_fault), 64'h0);
    step();
    chk("s2_pc", ipc, 64'h4);
    chk("s2_inst", 64'(inst), 64'h0010_0093);
    chk("wrap2_pc", w_pc, 64'h0);
    chk("wrap2_valid", 64'(w_valid), 64'h1);
    chk("wrap2_addr", w_addr, 64'h4);
    repeat (4) step();

    // Back-pressure fills the buffer, then drains without a gap.
    do_reset();
    ready = 1'b0;
    repeat (5) step();
    chk("fill_addr", rom_addr, 64'h8);
    chk("fill_head", ipc, 64'h0);
    ready = 1'b1;
    step(); chk("drain_4", ipc, 64'h4);
    step(); chk("drain_8", ipc, 64'h8);
    step(); chk("drain_c", ipc, 64'hC);

    // Redirect flushes buffered 0x8/0xC.
    do_reset();
    ready = 1'b0;
    step(); step();
    ready = 1'b1;
    step(); step();
    chk("pre_redir_head", ipc, 64'h8);
    ready    = 1'b0;
    redirect = 1'b1;
    target   = 64'h100;
    step();
    chk("redir_flush", 64'(valid), 64'h0);
    redirect = 1'b0;
    step();
    chk("redir_valid", 64'(valid), 64'h1);
    chk("redir_pc", ipc, 64'h100);

    // Misaligned target: one fault entry, then halted.
    redirect = 1'b1;
    target   = 64'h102;
    step();
    redirect = 1'b0;
    step();
    chk("mis_pc", ipc, 64'h102);
    chk("mis_fault", 64'(fault), 64'h1);
    chk("mis_inst", 64'(inst), 64'h0);
    ready = 1'b1;
    repeat (3) step();
    chk("halt_valid", 64'(valid), 64'h0);
    chk("halt_addr", rom_addr, 64'h102);
    redirect = 1'b1;
    target   = 64'h200;
    step();
    redirect = 1'b0;
    step();
    chk("resume_pc", ipc, 64'h200);

    // Asynchronous reset mid-stream.
    ready = 1'b0;
    step(); step();
    chk("pre_arst_valid", 64'(valid), 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'h0);
    chk("arst_addr", rom_addr, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fetched", fcnt, 64'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    chk("arst_restart_pc", ipc, 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      target   = {32'h0, $urandom} & 64'h0000_0000_000F_FFFC;
      if ($urandom_range(0, 3) == 0) target[1:0] = 2'($urandom_range(1, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
